sopc_led_fader: RTL and testbench



---
 rtl/sopc_led_fader_pkg.sv | 15 +
 rtl/sopc_led_fader_if.sv | 30 +++
 rtl/sopc_led_fader_channel.sv | 67 ++++++
 rtl/sopc_led_fader.sv | 76 +++++++
 tb/tb_sopc_led_fader.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sopc_led_fader_pkg.sv
// sopc_led_fader_pkg: shared constants, types and helpers
// for the LED PWM fader slice.
package sopc_led_fader_pkg;

  localparam int N_LEDS       = 8;
  localparam int DEF_PWM_BITS = 8;

  typedef logic [DEF_PWM_BITS-1:0] level_t;
  typedef logic [DEF_PWM_BITS:0]   level_ext_t;

  function automatic int pwm_max(input int bits);
    return (1 << bits) - 1;
  endfunction

endpackage

// File: rtl/sopc_led_fader_if.sv
// sopc_led_fader_if: PIO-side pattern/brightness controls
// and board-side LED drive of the fader.
interface sopc_led_fader_if #(
  parameter int PWM_BITS = 8
);
  import sopc_led_fader_pkg::*;

  logic [N_LEDS-1:0]   pattern_in;
  logic [PWM_BITS-1:0] brightness;
  logic                enable;
  logic [N_LEDS-1:0]   led_out;
  logic                busy;

  modport master (
    output pattern_in,
    output brightness,
    output enable,
    input  led_out,
    input  busy
  );

  modport slave (
    input  pattern_in,
    input  brightness,
    input  enable,
    output led_out,
    output busy
  );

endinterface

// File: rtl/sopc_led_fader_channel.sv
// led_fade_channel: one LED's fade level, period-latched
// duty shadow and PWM compare.
module led_fade_channel
  import sopc_led_fader_pkg::*;
#(
  parameter int PWM_BITS  = 8,
  parameter int FADE_STEP = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PWM_BITS-1:0] target,
  input  logic                step_tick,
  input  logic                period_end,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                enable,
  output logic                led,
  output logic                at_target
);

  localparam int W = PWM_BITS + 1;
  localparam logic [W-1:0] STEP_X =
    W'(FADE_STEP);
  localparam logic [PWM_BITS-1:0] STEP_N =
    PWM_BITS'(FADE_STEP);

  if (FADE_STEP < 1) begin : g_bad_step
    $error("FADE_STEP must be >= 1");
  end

  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [W-1:0]        lvl_x, tgt_x, up_x;
  logic [PWM_BITS-1:0] dn;

  // Extra bit keeps level+step from wrapping
  always_comb begin
    lvl_x   = {1'b0, level_q};
    tgt_x   = {1'b0, target};
    up_x    = lvl_x + STEP_X;
    dn      = level_q - STEP_N;
    level_d = level_q;
    unique case (1'b1)
      step_tick && (lvl_x < tgt_x):
        level_d = (up_x >= tgt_x) ?
          target : up_x[PWM_BITS-1:0];
      step_tick && (lvl_x > tgt_x):
        level_d = (lvl_x <= tgt_x + STEP_X) ?
          target : dn;
      default: ;
    endcase
  end

  assign duty_d    = period_end ? level_q : duty_q;
  assign led       = enable & (duty_q > pwm_cnt);
  assign at_target = (level_q == target);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= '0;
      duty_q  <= '0;
    end else begin
      level_q <= level_d;
      duty_q  <= duty_d;
    end
  end

endmodule

// File: rtl/sopc_led_fader.sv
// sopc_led_fader: eight PWM LED faders sharing one
// step prescaler and one PWM period counter.
module sopc_led_fader
  import sopc_led_fader_pkg::*;
#(
  parameter int PWM_BITS  = 8,
  parameter int STEP_DIV  = 1024,
  parameter int FADE_STEP = 1
) (
  input logic           clk,
  input logic           reset_n,
  sopc_led_fader_if.slave bus
);

  localparam int PMAX = pwm_max(PWM_BITS);
  localparam logic [PWM_BITS-1:0] PWM_TOP =
    PWM_BITS'(PMAX - 1);
  localparam int PSW =
    (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PSW-1:0] PS_TOP =
    PSW'(STEP_DIV - 1);

  logic [PSW-1:0]      presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic                step_tick, period_end;
  logic [N_LEDS-1:0]   led_d, led_q;
  logic [N_LEDS-1:0]   at_tgt;
  logic                busy_d, busy_q;

  assign step_tick  = (presc_q == PS_TOP);
  assign period_end = (pwm_q == PWM_TOP);
  assign presc_d    = step_tick ?
    '0 : presc_q + PSW'(1);
  assign pwm_d      = period_end ?
    '0 : pwm_q + PWM_BITS'(1);
  assign busy_d     = ~&at_tgt;

  for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
    logic [PWM_BITS-1:0] tgt;
    assign tgt = bus.pattern_in[i] ?
      bus.brightness : '0;

    led_fade_channel #(
      .PWM_BITS  (PWM_BITS),
      .FADE_STEP (FADE_STEP)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .target     (tgt),
      .step_tick  (step_tick),
      .period_end (period_end),
      .pwm_cnt    (pwm_q),
      .enable     (bus.enable),
      .led        (led_d[i]),
      .at_target  (at_tgt[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      pwm_q   <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      pwm_q   <= pwm_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.led_out = led_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_sopc_led_fader.sv
// tb_sopc_led_fader: two fader instances (step 1 and 4)
// against a cycle-level arithmetic reference model.
module tb_sopc_led_fader;
  import sopc_led_fader_pkg::*;

  localparam int PB  = 4;
  localparam int SD  = 2;
  localparam int PER = (1 << PB) - 1;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    pat     = '0;
  logic [PB-1:0] bri     = '0;
  logic          en      = 1'b1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sopc_led_fader_if #(.PWM_BITS(PB)) if_a ();
  sopc_led_fader_if #(.PWM_BITS(PB)) if_b ();

  assign if_a.pattern_in = pat;
  assign if_a.brightness = bri;
  assign if_a.enable     = en;
  assign if_b.pattern_in = pat;
  assign if_b.brightness = bri;
  assign if_b.enable     = en;

  sopc_led_fader #(
    .PWM_BITS(PB), .STEP_DIV(SD), .FADE_STEP(1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(if_a.slave)
  );

  sopc_led_fader #(
    .PWM_BITS(PB), .STEP_DIV(SD), .FADE_STEP(4)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(if_b.slave)
  );

  logic [PB-1:0] lvl_a [8];
  logic [PB-1:0] lvl_b [8];
  for (genvar g = 0; g < 8; g++) begin : g_obs
    assign lvl_a[g] = dut_a.g_ch[g].u_ch.level_q;
    assign lvl_b[g] = dut_b.g_ch[g].u_ch.level_q;
  end

  int       m_presc, m_pwm;
  int       m_lvl  [2][8];
  int       m_duty [2][8];
  logic [7:0] m_led [2];
  logic     m_busy [2];

  function automatic int fs(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  task automatic m_clear();
    m_presc = 0;
    m_pwm   = 0;
    for (int k = 0; k < 2; k++) begin
      m_led[k]  = '0;
      m_busy[k] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        m_lvl[k][i]  = 0;
        m_duty[k][i] = 0;
      end
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Advance model and DUTs one clock, then compare
  task automatic tick();
    bit stp, pe;
    int tg;
    stp = (m_presc == SD - 1);
    pe  = (m_pwm == PER - 1);
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tg = pat[i] ? int'(bri) : 0;
        m_led[k][i] = en && (m_duty[k][i] > m_pwm);
        if (m_lvl[k][i] != tg) m_busy[k] = 1'b1;
        if (pe) m_duty[k][i] = m_lvl[k][i];
        if (stp && m_lvl[k][i] < tg)
          m_lvl[k][i] = (m_lvl[k][i] + fs(k) > tg) ?
            tg : m_lvl[k][i] + fs(k);
        else if (stp && m_lvl[k][i] > tg)
          m_lvl[k][i] = (m_lvl[k][i] - fs(k) < tg) ?
            tg : m_lvl[k][i] - fs(k);
      end
    end
    m_presc = (m_presc + 1) % SD;
    m_pwm   = (m_pwm + 1) % PER;
    @(posedge clk);
    #1;
    if (!reset_n) m_clear();
    chk("led_a", if_a.led_out, m_led[0]);
    chk("busy_a", if_a.busy, m_busy[0]);
    chk("led_b", if_b.led_out, m_led[1]);
    chk("busy_b", if_b.busy, m_busy[1]);
    for (int i = 0; i < 8; i++) begin
      chk("lvl_a", lvl_a[i], m_lvl[0][i]);
      chk("lvl_b", lvl_b[i], m_lvl[1][i]);
    end
  endtask

  task automatic rst_pulse();
    #2 reset_n = 1'b0;
    #1 m_clear();
    tick();
    reset_n = 1'b1;
  endtask

  int n, cnt, prev, mx;
  int seq [$];
  int exp_seq [7];

  initial begin
    exp_seq = '{0, 4, 8, 10, 6, 2, 0};
    m_clear();
    pat = 8'hFF;
    bri = 4'd15;
    en  = 1'b1;
    repeat (3) tick();
    chk("rst_led", if_a.led_out, 8'h00);
    chk("rst_busy", if_a.busy, 1'b0);
    reset_n = 1'b1;
    tick();
    tick();
    chk("rel_busy", if_a.busy, 1'b1);

    pat = 8'h00;
    rst_pulse();
    pat = 8'h01;
    n = 0;
    while (lvl_a[0] != 4'd15 && n < 100) begin
      tick();
      n++;
    end
    chk("fade_clks", n, 30);
    chk("fade_busy_hi", if_a.busy, 1'b1);
    tick();
    chk("fade_busy_lo", if_a.busy, 1'b0);
    repeat (2 * PER) tick();
    repeat (PER) begin
      tick();
      chk("fade_full", if_a.led_out, 8'h01);
    end

    pat = 8'h00;
    rst_pulse();
    pat = 8'h08;
    bri = 4'd5;
    repeat (3 * PER) tick();
    cnt = 0;
    repeat (PER) begin
      tick();
      cnt += int'(if_a.led_out[3]);
    end
    chk("duty_cnt", cnt, 5);

    pat = 8'h00;
    rst_pulse();
    pat = 8'h04;
    bri = 4'd15;
    n = 0;
    while (lvl_a[2] != 4'd7 && n < 100) begin
      tick();
      n++;
    end
    chk("rev_reach", lvl_a[2], 7);
    pat  = 8'h00;
    prev = 7;
    mx   = 7;
    n    = 0;
    while (lvl_a[2] != 4'd0 && n < 100) begin
      tick();
      n++;
      if (int'(lvl_a[2]) > mx) mx = int'(lvl_a[2]);
      if (int'(lvl_a[2]) != prev) begin
        chk("rev_step", lvl_a[2], prev - 1);
        prev = int'(lvl_a[2]);
      end
    end
    chk("rev_max", mx, 7);
    chk("rev_end", lvl_a[2], 0);

    pat = 8'h00;
    rst_pulse();
    pat = 8'h01;
    bri = 4'd10;
    seq.delete();
    seq.push_back(int'(lvl_b[0]));
    n = 0;
    while (n < 200) begin
      tick();
      n++;
      if (int'(lvl_b[0]) != seq[$])
        seq.push_back(int'(lvl_b[0]));
      if (lvl_b[0] == 4'd10) pat = 8'h00;
      if (pat == 8'h00 && lvl_b[0] == 4'd0) break;
    end
    chk("sat_len", seq.size(), 7);
    for (int i = 0; i < 7; i++)
      chk("sat_seq", (i < seq.size()) ? seq[i] : -1,
          exp_seq[i]);

    pat = 8'h00;
    rst_pulse();
    pat = 8'hFF;
    bri = 4'd15;
    repeat (12) tick();
    en = 1'b0;
    tick();
    chk("en_off_a", if_a.led_out, 8'h00);
    chk("en_off_b", if_b.led_out, 8'h00);
    repeat (6) tick();
    chk("en_ramp", lvl_a[0], 9);
    en = 1'b1;
    tick();
    chk("en_on", if_a.led_out, 8'hFF);

    repeat (600) begin
      if ($urandom_range(7) == 0) pat = 8'($urandom);
      if ($urandom_range(15) == 0) bri = PB'($urandom);
      if ($urandom_range(15) == 0)
        en = ($urandom_range(7) != 0);
      tick();
    end

    en  = 1'b1;
    pat = 8'h00;
    rst_pulse();
    pat = 8'hFF;
    bri = 4'd15;
    repeat (20) tick();
    chk("pre_arst_led", if_a.led_out, 8'hFF);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_led", if_a.led_out, 8'h00);
    chk("arst_busy", if_a.busy, 1'b0);
    chk("arst_lvl", lvl_a[0], 0);
    m_clear();
    tick();
    reset_n = 1'b1;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
